// File: rtl/axi4_stream_initiator_arbiter.sv
// Packet-granular round-robin arbiter that merges NumInitiators AXI4-Stream sources onto one
// registered master port with full tready backpressure.
module axi4_stream_initiator_arbiter #(
  parameter int unsigned NumInitiators = 4,
  parameter int unsigned TDataWidth    = 32,
  parameter int unsigned TIdWidth      = 8,
  parameter int unsigned TDestWidth    = 8
) (
  input  logic                               clk_axis_i,
  input  logic                               rst_axis_i,
  input  logic [NumInitiators-1:0]           s_axis_tvalid_i,
  output logic [NumInitiators-1:0]           s_axis_tready_o,
  input  logic [NumInitiators*TDataWidth-1:0] s_axis_tdata_i,
  input  logic [NumInitiators-1:0]           s_axis_tlast_i,
  input  logic [NumInitiators*TIdWidth-1:0]   s_axis_tid_i,
  input  logic [NumInitiators*TDestWidth-1:0] s_axis_tdest_i,
  output logic                               m_axis_tvalid_o,
  input  logic                               m_axis_tready_i,
  output logic [TDataWidth-1:0]              m_axis_tdata_o,
  output logic                               m_axis_tlast_o,
  output logic [TIdWidth-1:0]                m_axis_tid_o,
  output logic [TDestWidth-1:0]              m_axis_tdest_o,
  output logic [NumInitiators-1:0]           grant_o,
  output logic                               busy_o
);

  localparam int unsigned IdxW = $clog2(NumInitiators);
  localparam logic [NumInitiators-1:0] OneHot0 = NumInitiators'(1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e                   state_q;
  logic [NumInitiators-1:0] grant_q;
  // Holds the granted index while busy and the round-robin pointer while idle.
  logic [IdxW-1:0]          last_q;
  logic                     m_valid_q, m_last_q;
  logic [TDataWidth-1:0]    m_data_q;
  logic [TIdWidth-1:0]      m_id_q;
  logic [TDestWidth-1:0]    m_dest_q;

  logic [IdxW-1:0]          sel_idx, scan_idx;
  logic                     req_found, out_free, beat_acc;
  logic [TDataWidth-1:0]    g_data;
  logic                     g_last;
  logic [TIdWidth-1:0]      g_id;
  logic [TDestWidth-1:0]    g_dest;

  // First requester strictly after last_q, wrapping.
  always_comb begin
    sel_idx   = '0;
    scan_idx  = '0;
    req_found = 1'b0;
    for (int unsigned i = 1; i <= NumInitiators; i++) begin
      scan_idx = IdxW'((32'(last_q) + i) % NumInitiators);
      if (!req_found && s_axis_tvalid_i[scan_idx]) begin
        req_found = 1'b1;
        sel_idx   = scan_idx;
      end
    end
  end

  assign g_data = s_axis_tdata_i[32'(last_q)*TDataWidth +: TDataWidth];
  assign g_last = s_axis_tlast_i[last_q];
  assign g_id   = s_axis_tid_i[32'(last_q)*TIdWidth +: TIdWidth];
  assign g_dest = s_axis_tdest_i[32'(last_q)*TDestWidth +: TDestWidth];

  always_comb begin
    out_free        = !m_valid_q || m_axis_tready_i;
    s_axis_tready_o = (state_q == StBusy && out_free) ? grant_q : '0;
    beat_acc        = |(s_axis_tready_o & s_axis_tvalid_i);
  end

  always_ff @(posedge clk_axis_i or posedge rst_axis_i) begin
    if (rst_axis_i) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      last_q    <= IdxW'(NumInitiators - 1);
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
      m_id_q    <= '0;
      m_dest_q  <= '0;
    end else begin
      if (out_free) begin
        m_valid_q <= beat_acc;
        if (beat_acc) begin
          m_data_q <= g_data;
          m_last_q <= g_last;
          m_id_q   <= g_id;
          m_dest_q <= g_dest;
        end
      end
      unique case (state_q)
        StIdle: begin
          if (req_found) begin
            grant_q <= OneHot0 << sel_idx;
            last_q  <= sel_idx;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (beat_acc && g_last) begin
            grant_q <= '0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign m_axis_tvalid_o = m_valid_q;
  assign m_axis_tdata_o  = m_data_q;
  assign m_axis_tlast_o  = m_last_q;
  assign m_axis_tid_o    = m_id_q;
  assign m_axis_tdest_o  = m_dest_q;
  assign grant_o         = grant_q;
  assign busy_o          = (state_q == StBusy);

endmodule

// File: tb/tb_axi4_stream_initiator_arbiter.sv
// Bench for axi4_stream_initiator_arbiter: vector table, random traffic against a queue-based
// reference model, and reset corner cases.
module tb_axi4_stream_initiator_arbiter;

  localparam int N = 4;

  logic          clk = 1'b0, rst = 1'b1;
  logic [N-1:0]  v, l, s_tready, grant;
  logic [127:0]  s_tdata;
  logic [31:0]   s_tid, s_tdest;
  logic          m_tvalid, m_rdy, m_tlast, busy;
  logic [31:0]   m_tdata;
  logic [7:0]    m_tid, m_tdest;
  logic [31:0]   d [N];
  logic [7:0]    id [N], de [N];

  always #5 clk = ~clk;

  always_comb begin
    s_tdata = '0;
    s_tid   = '0;
    s_tdest = '0;
    for (int k = 0; k < N; k++) begin
      s_tdata[k*32 +: 32] = d[k];
      s_tid[k*8 +: 8]     = id[k];
      s_tdest[k*8 +: 8]   = de[k];
    end
  end

  axi4_stream_initiator_arbiter #(
    .NumInitiators(N), .TDataWidth(32), .TIdWidth(8), .TDestWidth(8)
  ) dut (
    .clk_axis_i(clk), .rst_axis_i(rst),
    .s_axis_tvalid_i(v), .s_axis_tready_o(s_tready), .s_axis_tdata_i(s_tdata),
    .s_axis_tlast_i(l), .s_axis_tid_i(s_tid), .s_axis_tdest_i(s_tdest),
    .m_axis_tvalid_o(m_tvalid), .m_axis_tready_i(m_rdy), .m_axis_tdata_o(m_tdata),
    .m_axis_tlast_o(m_tlast), .m_axis_tid_o(m_tid), .m_axis_tdest_o(m_tdest),
    .grant_o(grant), .busy_o(busy)
  );

  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: packet-level round-robin plus a one-deep output holding queue.
  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [7:0]  id;
    logic [7:0]  dest;
  } beat_t;

  beat_t        out_q[$];
  bit           m_busy;
  int           m_gnt, m_ptr;
  logic [N-1:0] acc;

  task automatic model_step();
    logic [N-1:0] etr, eg;
    bit free, found;
    free = (out_q.size() == 0) || m_rdy;
    etr  = '0;
    if (m_busy && free) etr[m_gnt] = 1'b1;
    eg = m_busy ? N'(1 << m_gnt) : '0;
    chk("s_tready", s_tready, etr);
    chk("grant", grant, eg);
    chk("busy", busy, m_busy);
    chk("m_tvalid", m_tvalid, out_q.size() != 0);
    if (out_q.size() != 0) begin
      chk("m_tdata", m_tdata, out_q[0].data);
      chk("m_tlast", m_tlast, out_q[0].last);
      chk("m_tid", m_tid, out_q[0].id);
      chk("m_tdest", m_tdest, out_q[0].dest);
    end
    acc = v & etr;
    if (out_q.size() != 0 && m_rdy) void'(out_q.pop_front());
    if (m_busy) begin
      if (acc[m_gnt]) begin
        out_q.push_back('{d[m_gnt], l[m_gnt], id[m_gnt], de[m_gnt]});
        if (l[m_gnt]) m_busy = 0;
      end
    end else if (v != '0) begin
      found = 0;
      for (int i = 1; i <= N; i++) begin
        int j;
        j = (m_ptr + i) % N;
        if (!found && v[j]) begin
          found  = 1;
          m_gnt  = j;
          m_ptr  = j;
          m_busy = 1;
        end
      end
    end
  endtask

  task automatic do_reset();
    v = '0; l = '0; m_rdy = 1'b1; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst m_tvalid", m_tvalid, 0);
    chk("rst m_tdata", m_tdata, 0);
    chk("rst m_tlast", m_tlast, 0);
    chk("rst m_tid", m_tid, 0);
    chk("rst m_tdest", m_tdest, 0);
    chk("rst grant", grant, 0);
    chk("rst busy", busy, 0);
    chk("rst s_tready", s_tready, 0);
    rst = 1'b0;
    m_busy = 0; m_ptr = N - 1; m_gnt = 0; out_q.delete(); acc = '0;
  endtask

  typedef struct packed {
    logic [3:0] v, l;
    logic       rdy;
    logic [3:0] gnt, trdy;
    logic       busy, mv, ml;
    logic [7:0] md;
  } vec_t;

  vec_t tbl [16];

  initial begin
    tbl = '{
      '{4'b1111, 4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00},
      '{4'b1111, 4'b1111, 1'b1, 4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0, 8'h00},
      '{4'b1111, 4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 8'hD0},
      '{4'b1111, 4'b1111, 1'b1, 4'b0010, 4'b0010, 1'b1, 1'b0, 1'b0, 8'h00},
      '{4'b1111, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 8'hD1},
      '{4'b1111, 4'b1111, 1'b0, 4'b0100, 4'b0000, 1'b1, 1'b1, 1'b1, 8'hD1},
      '{4'b1111, 4'b1111, 1'b1, 4'b0100, 4'b0100, 1'b1, 1'b1, 1'b1, 8'hD1},
      '{4'b1111, 4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 8'hD2},
      '{4'b0010, 4'b0000, 1'b1, 4'b1000, 4'b1000, 1'b1, 1'b0, 1'b0, 8'h00},
      '{4'b0111, 4'b0000, 1'b1, 4'b1000, 4'b1000, 1'b1, 1'b0, 1'b0, 8'h00},
      '{4'b1000, 4'b0000, 1'b1, 4'b1000, 4'b1000, 1'b1, 1'b0, 1'b0, 8'h00},
      '{4'b1000, 4'b1000, 1'b1, 4'b1000, 4'b1000, 1'b1, 1'b1, 1'b0, 8'hD3},
      '{4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 8'hD3},
      '{4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00},
      '{4'b0011, 4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00},
      '{4'b0011, 4'b1111, 1'b1, 4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0, 8'h00}
    };
    for (int k = 0; k < N; k++) begin
      d[k] = 32'hD0 + 32'(k); id[k] = 8'(8'h10 + k); de[k] = 8'(8'h20 + k);
    end

    do_reset();
    for (int r = 0; r < 16; r++) begin
      v = tbl[r].v; l = tbl[r].l; m_rdy = tbl[r].rdy;
      @(negedge clk);
      chk($sformatf("vec%0d grant", r), grant, tbl[r].gnt);
      chk($sformatf("vec%0d s_tready", r), s_tready, tbl[r].trdy);
      chk($sformatf("vec%0d busy", r), busy, tbl[r].busy);
      chk($sformatf("vec%0d m_tvalid", r), m_tvalid, tbl[r].mv);
      if (tbl[r].mv) begin
        chk($sformatf("vec%0d m_tdata", r), m_tdata, {24'h0, tbl[r].md});
        chk($sformatf("vec%0d m_tlast", r), m_tlast, tbl[r].ml);
        chk($sformatf("vec%0d m_tid", r), m_tid, {4'h1, tbl[r].md[3:0]});
      end
      @(posedge clk); #1;
    end

    // Random traffic; sources keep a beat stable until it is accepted.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!v[k] || acc[k]) begin
          v[k]  = ($urandom_range(0, 3) != 0);
          l[k]  = ($urandom_range(0, 3) == 0);
          d[k]  = $urandom;
          id[k] = 8'(8'h10 + k);
          de[k] = 8'($urandom);
        end
      end
      m_rdy = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      model_step();
      @(posedge clk); #1;
    end

    // Reset in the middle of a packet from initiator 2.
    do_reset();
    v = 4'b0100; l = 4'b0000; m_rdy = 1'b1; d[2] = 32'hC2;
    repeat (3) begin
      @(negedge clk);
      model_step();
      @(posedge clk); #1;
    end
    chk("pre-rst m_tvalid", m_tvalid, 1);
    #2 rst = 1'b1;
    #1;
    chk("async-rst m_tvalid", m_tvalid, 0);
    chk("async-rst grant", grant, 0);
    chk("async-rst busy", busy, 0);
    @(posedge clk); #1;
    v = 4'b0101; l = 4'b1111; rst = 1'b0;
    m_busy = 0; m_ptr = N - 1; m_gnt = 0; out_q.delete();
    @(negedge clk);
    model_step();
    @(posedge clk); #1;
    @(negedge clk);
    chk("post-rst first grant", grant, 4'b0001);
    model_step();
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi4_stream_initiator_arbiter.md
Name: axi4_stream_initiator_arbiter

Overview:
- Shares one AXI4-Stream master port among NumInitiators stream initiators, such as type-1 data initiators.
- Arbitration is round-robin at packet granularity: a grant is held from the first beat through the tlast beat.
- Sits between the local initiators and the NoC network-interface ingress.
- Output is a single registered stage with full tready backpressure.

Parameters:
- NumInitiators, 4, number of requesting streams (2..16).
- TDataWidth, 32, tdata width in bits per stream.
- TIdWidth, 8, tid width in bits.
- TDestWidth, 8, tdest width in bits.

Ports:
- clk_axis_i  in  1  clock; all logic is on the rising edge.
- rst_axis_i  in  1  reset, asynchronous, active-high.
- s_axis_tvalid_i  in  NumInitiators  per-initiator tvalid.
- s_axis_tready_o  out  NumInitiators  per-initiator tready.
- s_axis_tdata_i  in  NumInitiators*TDataWidth  flattened; initiator k occupies slice [k*TDataWidth +: TDataWidth].
- s_axis_tlast_i  in  NumInitiators  per-initiator tlast.
- s_axis_tid_i  in  NumInitiators*TIdWidth  flattened tid.
- s_axis_tdest_i  in  NumInitiators*TDestWidth  flattened tdest.
- m_axis_tvalid_o  out  1  arbitrated output valid.
- m_axis_tready_i  in  1  downstream ready.
- m_axis_tdata_o  out  TDataWidth  arbitrated data.
- m_axis_tlast_o  out  1  arbitrated tlast.
- m_axis_tid_o  out  TIdWidth  tid of the granted initiator, passed through unmodified.
- m_axis_tdest_o  out  TDestWidth  tdest of the granted initiator, passed through unmodified.
- grant_o  out  NumInitiators  one-hot current grant; all zero when IDLE.
- busy_o  out  1  high while in state BUSY.

Behaviour:
- Reset (async assert, sync release) values:
  - m_axis_tvalid_o=0; tdata/tlast/tid/tdest=0.
  - grant_o=0, busy_o=0, state=IDLE.
  - RR pointer last_q=NumInitiators-1, so initiator 0 has highest priority first.
- State IDLE:
  - s_axis_tready_o=0 for all initiators.
  - If any s_axis_tvalid_i bit is set, select the first set bit searching (last_q+1) mod N upward with wrap.
  - At the clock edge: grant_o <= onehot(sel), last_q <= sel, state <= BUSY.
  - Arbitration latency is 1 cycle from a request seen in IDLE to tready assertion.
- State BUSY:
  - Output register free: out_free = !m_axis_tvalid_o || m_axis_tready_i.
  - s_axis_tready_o[g] = out_free; all other tready bits are 0 (combinational).
  - On an accepted input beat (tvalid[g] && tready[g]): load the output register with initiator g's tdata/tlast/tid/tdest and set m_axis_tvalid_o=1.
  - If out_free but no input beat: m_axis_tvalid_o <= 0.
  - If !out_free: hold all output fields stable (AXI rule: no change while valid && !ready).
  - On an accepted input beat with tlast=1: state <= IDLE, grant_o <= 0, at the same edge.
- Throughput and latency:
  - Input-to-output latency is 1 cycle.
  - Sustained rate is 1 beat/cycle within a packet.
  - One idle arbitration cycle on s-side between packets; the m-side may still be draining the tlast beat during it.
- Boundary conditions:
  - Granted initiator drops tvalid mid-packet: grant is held indefinitely; no other initiator is served (packet atomicity).
  - Non-granted initiators that assert tvalid see tready=0; their data must stay stable per AXI.
  - Single-beat packet (tlast on first beat): BUSY lasts exactly one accepted beat.
  - All initiators requesting continuously: service order is 0,1,...,N-1,0,... (wrap-around).
  - Only one initiator requesting: it is re-granted after every packet, with one IDLE cycle between packets.
  - m_axis_tready_i held 0: at most one beat is held in the output register; s-side tready stays 0.
  - Reset mid-packet: partial packet is discarded, outputs are cleared immediately, and the RR pointer restarts at 0.
  - A tvalid request arriving in the same cycle as the IDLE-to-BUSY transition has no effect until the next IDLE.
- Width rule: slices are indexed k*Width +: Width; no width conversion is performed.

Test Plan:
- Reset and idle: rst_axis_i pulsed high for 2 cycles, no requests -> all outputs 0, grant_o=0, busy_o=0; async assert clears a pending m_axis_tvalid_o=1 before the next clock edge.
- Round-robin fairness: N=4, all initiators send 2-beat packets continuously, m_tready=1 -> grant sequence 0001,0010,0100,1000,0001; 8 beats out in that order; tid equals the source tid (0x10..0x13).
- Packet atomicity: initiator 1 deasserts tvalid for 3 cycles mid-packet while initiator 2 requests -> grant_o stays 0010 until initiator 1's tlast is accepted; only then does initiator 2 get 0100.
- Backpressure: m_tready pattern 1,0,0,1 during a 4-beat packet from initiator 0 (data 0xA0..0xA3) -> output fields stable while stalled; the 4 beats appear once each, in order, with tlast only on 0xA3.
- Single-beat packets: initiator 3 alone sends tlast=1 every beat -> accepted beats every 2nd cycle; grant_o toggles 1000/0000; m_axis_tlast_o=1 on each output beat.
- Reset mid-packet: assert rst after beat 2 of a 4-beat packet from initiator 2 -> m_axis_tvalid_o=0 at once; after release with initiators 0 and 2 requesting, first grant is 0001.
